core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Run controller that sequences the single-cycle RISC-V core.
- Holds the core in reset while a program is streamed into instruction memory, then releases it.
- Grants execution as free-run or single-step, and stops on a halt request or an ECALL retire.
- Sits between the top-level `clk`/`rst` and the core's reset, PC/register-write enable and imem write port.

Parameters:
- HOLD_CYC, 2, cycles spent in RESET_HOLD before loading (≥1)
- IMEM_WORDS, 64, instruction-memory depth in 32-bit words (power of 2)
- CNT_W, 32, width of cycle_count

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  loader word valid
- load_data  in  32  loader instruction word
- load_last  in  1  marks final word of program
- load_ready  out  1  controller accepts a word this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_waddr  out  32  byte address of write (word index << 2)
- imem_wdata  out  32  write data
- run_req  in  1  start/resume free-running
- step_req  in  1  execute exactly one instruction
- halt_req  in  1  stop execution
- restart_req  in  1  re-enter reset/load sequence
- ecall_hit  in  1  core decodes 0x00000073 this cycle
- core_rst_n  out  1  active-low reset to core datapath
- core_en  out  1  PC/regfile/dmem write enable
- state  out  3  current FSM state encoding
- cycle_count  out  CNT_W  enabled core cycles since last load
- load_ovf  out  1  program exceeded IMEM_WORDS (sticky)

Behaviour:
- State encodings: RESET_HOLD=0, LOAD=1, READY=2, RUN=3, STEP=4, PAUSED=5, HALTED=6. Code 7 is unreachable and decodes to RESET_HOLD next cycle.
- Reset (`rst`=1 at an edge):
  - state becomes RESET_HOLD, hold counter is cleared.
  - Word pointer, cycle_count and load_ovf become 0.
  - Outputs: core_rst_n=0, core_en=0, load_ready=0, imem_we=0.
  - `rst` overrides every other input, including mid-load or mid-run.
- Moore outputs: core_rst_n=1 only in RUN, STEP, PAUSED and HALTED. core_en=1 only in RUN and STEP. load_ready=1 only in LOAD.
- RESET_HOLD:
  - Stays for exactly HOLD_CYC cycles, then goes to LOAD.
  - On entry from restart: pointer, cycle_count and load_ovf are cleared.
- LOAD:
  - imem_we = load_valid & load_ready (combinational); imem_wdata = load_data; imem_waddr = ptr<<2.
  - Each accepted word increments ptr in the next cycle.
  - Accepted word with load_last=1: go to READY.
  - Accepted word at ptr=IMEM_WORDS-1 with load_last=0: write it, set load_ovf=1, go to READY. Further words are never written (no wrap).
  - load_valid=0: state unchanged, no write.
- READY:
  - Core is still held in reset.
  - run_req: go to RUN. step_req alone: go to STEP. run_req and step_req together: run wins.
  - halt_req is ignored.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - halt_req or ecall_hit: go to HALTED next cycle. The sampling cycle is counted, so the ECALL instruction retires.
  - run_req and step_req are ignored.
- STEP:
  - Lasts exactly one cycle; cycle_count increments by 1.
  - Next state is HALTED if ecall_hit or halt_req, else PAUSED.
- PAUSED:
  - run_req: RUN. step_req: STEP. halt_req: HALTED. restart_req: RESET_HOLD.
  - Priority: restart > halt > run > step.
- HALTED:
  - Sticky; only restart_req (to RESET_HOLD) or `rst` leaves it.
  - cycle_count is held.
- Latency: a request sampled at edge N takes effect at edge N+1, so core_en changes one cycle after the request.
- restart_req is ignored in RESET_HOLD, LOAD, READY and RUN. Halt first.

Test Plan:
- Reset and hold: `rst`=1 for 2 cycles, then 0 with HOLD_CYC=2 → state 0 for 2 cycles, then state=1 and load_ready=1; core_rst_n=0 and core_en=0 throughout.
- Load: stream words 0x00500093, 0x00300113, 0x00000073 with load_last on the third; insert one load_valid=0 bubble → imem_we pulses 3 times at addresses 0x0, 0x4, 0x8 with matching data; no write in the bubble cycle; state=2; load_ovf=0.
- Free-run to ECALL: run_req pulse in READY; ecall_hit asserted on the 3rd RUN cycle → core_en=1 for exactly 3 cycles, then state=6, cycle_count=3, core_rst_n=1.
- Stepping: restart, reload, then step_req ×2 with gaps → each step gives exactly one core_en cycle; state returns to 5; cycle_count=2. Then run_req and step_req in the same cycle from PAUSED → RUN.
- Overflow: IMEM_WORDS=4, stream 6 words with no load_last → exactly 4 writes (addresses 0x0–0xC), load_ovf=1, state=2, load_ready=0 afterwards.
- Reset mid-run: assert `rst` during RUN with cycle_count=10 → next edge state=0, cycle_count=0, core_en=0, core_rst_n=0.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: holds the core in reset while
// instruction memory is loaded, then grants free-run or single-step execution.
module core_run_ctrl #(
    parameter int HOLD_CYC   = 2,
    parameter int IMEM_WORDS = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic             imem_we,
    output logic [31:0]      imem_waddr,
    output logic [31:0]      imem_wdata,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             restart_req,
    input  logic             ecall_hit,
    output logic             core_rst_n,
    output logic             core_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic             load_ovf
);

    // Pointer carries one extra bit so it can sit one past the last word after overflow.
    localparam int PTR_W  = $clog2(IMEM_WORDS) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_LOAD       = 3'd1,
        S_READY      = 3'd2,
        S_RUN        = 3'd3,
        S_STEP       = 3'd4,
        S_PAUSED     = 3'd5,
        S_HALTED     = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET_HOLD;
            hold_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_RESET_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    state_d = S_LOAD;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (load_last) begin
                        state_d = S_READY;
                    end else if (ptr_q == PTR_W'(IMEM_WORDS - 1)) begin
                        ovf_d   = 1'b1;
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (run_req)       state_d = S_RUN;
                else if (step_req) state_d = S_STEP;
            end
            S_RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (halt_req || ecall_hit) state_d = S_HALTED;
            end
            S_STEP: begin
                cnt_d   = sat_inc(cnt_q);
                state_d = (halt_req || ecall_hit) ? S_HALTED : S_PAUSED;
            end
            S_PAUSED: begin
                if (restart_req) begin
                    state_d = S_RESET_HOLD;
                    hold_d  = '0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (halt_req) begin
                    state_d = S_HALTED;
                end else if (run_req) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            S_HALTED: begin
                if (restart_req) begin
                    state_d = S_RESET_HOLD;
                    hold_d  = '0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                // Unused encoding recovers through the reset sequence.
                state_d = S_RESET_HOLD;
                hold_d  = '0;
            end
        endcase
    end

    assign load_ready  = (state_q == S_LOAD);
    assign imem_we     = load_valid & load_ready;
    assign imem_waddr  = 32'(ptr_q) << 2;
    assign imem_wdata  = load_data;
    assign core_rst_n  = (state_q == S_RUN) || (state_q == S_STEP) ||
                         (state_q == S_PAUSED) || (state_q == S_HALTED);
    assign core_en     = (state_q == S_RUN) || (state_q == S_STEP);
    assign state       = state_q;
    assign cycle_count = cnt_q;
    assign load_ovf    = ovf_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus a random phase, all checked
// every cycle against a behavioural model of the run/load sequencing rules.
module tb_core_run_ctrl;

    localparam int HOLD = 2;
    localparam int W    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load_valid, load_last, run_req, step_req, halt_req, restart_req, ecall_hit;
    logic [31:0] load_data;

    logic        load_ready, imem_we, core_rst_n, core_en, load_ovf;
    logic [31:0] imem_waddr, imem_wdata, cycle_count;
    logic [2:0]  state;

    logic        s_load_ready, s_imem_we, s_core_rst_n, s_core_en, s_load_ovf;
    logic [31:0] s_imem_waddr, s_imem_wdata;
    logic [3:0]  s_cycle_count;
    logic [2:0]  s_state;

    core_run_ctrl #(.HOLD_CYC(HOLD), .IMEM_WORDS(W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .run_req(run_req),
        .step_req(step_req), .halt_req(halt_req), .restart_req(restart_req),
        .ecall_hit(ecall_hit), .core_rst_n(core_rst_n), .core_en(core_en),
        .state(state), .cycle_count(cycle_count), .load_ovf(load_ovf));

    // Narrow counter instance exposes saturation behaviour.
    core_run_ctrl #(.HOLD_CYC(HOLD), .IMEM_WORDS(W), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(s_load_ready), .imem_we(s_imem_we),
        .imem_waddr(s_imem_waddr), .imem_wdata(s_imem_wdata), .run_req(run_req),
        .step_req(step_req), .halt_req(halt_req), .restart_req(restart_req),
        .ecall_hit(ecall_hit), .core_rst_n(s_core_rst_n), .core_en(s_core_en),
        .state(s_state), .cycle_count(s_cycle_count), .load_ovf(s_load_ovf));

    int errors = 0;
    int checks = 0;
    int n_we, n_en;

    int     m_st, m_hold, m_ptr;
    longint m_cnt;
    bit     m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_enter_hold();
        m_st = 0; m_hold = HOLD; m_ptr = 0; m_cnt = 0; m_ovf = 1'b0;
    endtask

    task automatic model_update();
        if (rst) begin
            model_enter_hold();
        end else begin
            case (m_st)
                0: begin
                    m_hold--;
                    if (m_hold == 0) m_st = 1;
                end
                1: if (load_valid) begin
                    if (load_last) m_st = 2;
                    else if (m_ptr == W - 1) begin m_ovf = 1'b1; m_st = 2; end
                    m_ptr++;
                end
                2: if (run_req) m_st = 3; else if (step_req) m_st = 4;
                3: begin
                    m_cnt++;
                    if (halt_req || ecall_hit) m_st = 6;
                end
                4: begin
                    m_cnt++;
                    m_st = (halt_req || ecall_hit) ? 6 : 5;
                end
                5: begin
                    if (restart_req) model_enter_hold();
                    else if (halt_req) m_st = 6;
                    else if (run_req) m_st = 3;
                    else if (step_req) m_st = 4;
                end
                6: if (restart_req) model_enter_hold();
                default: m_st = 0;
            endcase
        end
    endtask

    // Check every output against the model, then advance one clock.
    task automatic cycle();
        logic       e_we, e_lr, e_rn, e_en;
        logic [63:0] e_cnt;
        #1;
        e_lr  = (m_st == 1);
        e_we  = e_lr && load_valid;
        e_rn  = (m_st >= 3 && m_st <= 6);
        e_en  = (m_st == 3 || m_st == 4);
        e_cnt = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_cnt);
        chk("state", 64'(state), 64'(m_st));
        chk("load_ready", 64'(load_ready), 64'(e_lr));
        chk("imem_we", 64'(imem_we), 64'(e_we));
        chk("core_rst_n", 64'(core_rst_n), 64'(e_rn));
        chk("core_en", 64'(core_en), 64'(e_en));
        chk("load_ovf", 64'(load_ovf), 64'(m_ovf));
        chk("cycle_count", 64'(cycle_count), e_cnt);
        chk("sat_count", 64'(s_cycle_count), (m_cnt > 15) ? 64'd15 : 64'(m_cnt));
        chk("s_outs", 64'({s_load_ready, s_imem_we, s_core_rst_n, s_core_en, s_state, s_load_ovf}),
            64'({e_lr, e_we, e_rn, e_en, 3'(m_st), m_ovf}));
        if (e_we) begin
            chk("imem_waddr", 64'(imem_waddr), 64'(m_ptr * 4));
            chk("imem_wdata", 64'(imem_wdata), 64'(load_data));
            chk("s_waddr", 64'(s_imem_waddr), 64'(m_ptr * 4));
            chk("s_wdata", 64'(s_imem_wdata), 64'(load_data));
        end
        if (imem_we) n_we++;
        if (core_en) n_en++;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        run_req = 0; step_req = 0; halt_req = 0; restart_req = 0; ecall_hit = 0;
        load_valid = 0; load_last = 0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int b = budget;
        while (state !== 3'(s) && b > 0) begin
            cycle();
            b--;
        end
        chk("wait_state", 64'(state), 64'(s));
    endtask

    task automatic load_words(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_valid = 0; cycle();
            end
            load_valid = 1;
            load_data  = $urandom;
            load_last  = use_last && (i == n - 1);
            cycle();
        end
        load_valid = 0; load_last = 0;
    endtask

    initial begin
        idle();
        load_data = '0;
        rst = 1;
        model_update();
        @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 0;

        // Reset hold: two cycles in state 0, then LOAD.
        cycle();
        cycle();
        chk("hold_to_load", 64'(state), 64'd1);
        chk("hold_ready", 64'(load_ready), 64'd1);

        // Load three words with a bubble before the last.
        n_we = 0;
        load_valid = 1; load_data = 32'h0050_0093; cycle();
        load_data = 32'h0030_0113; cycle();
        load_valid = 0; cycle();
        load_valid = 1; load_data = 32'h0000_0073; load_last = 1; cycle();
        idle();
        chk("load_nwe", 64'(n_we), 64'd3);
        chk("load_state", 64'(state), 64'd2);
        chk("load_ovf0", 64'(load_ovf), 64'd0);

        // Free-run, ECALL on the third RUN cycle.
        run_req = 1; cycle(); run_req = 0;
        n_en = 0;
        cycle();
        cycle();
        ecall_hit = 1; cycle(); ecall_hit = 0;
        cycle();
        chk("run_nen", 64'(n_en), 64'd3);
        chk("ecall_state", 64'(state), 64'd6);
        chk("ecall_count", 64'(cycle_count), 64'd3);
        chk("ecall_rstn", 64'(core_rst_n), 64'd1);

        // Restart, reload, single-step twice.
        restart_req = 1; cycle(); restart_req = 0;
        wait_state(1, 10);
        load_words($urandom_range(1, 3), 1'b1);
        chk("reload_state", 64'(state), 64'd2);
        n_en = 0;
        step_req = 1; cycle(); step_req = 0;
        repeat ($urandom_range(1, 3)) cycle();
        step_req = 1; cycle(); step_req = 0;
        repeat (2) cycle();
        chk("step_nen", 64'(n_en), 64'd2);
        chk("step_state", 64'(state), 64'd5);
        chk("step_count", 64'(cycle_count), 64'd2);
        run_req = 1; step_req = 1; cycle(); idle();
        chk("run_wins", 64'(state), 64'd3);
        halt_req = 1; cycle(); halt_req = 0;
        chk("halt_state", 64'(state), 64'd6);

        // Overflow: six words without load_last into a four-word memory.
        restart_req = 1; cycle(); restart_req = 0;
        wait_state(1, 10);
        n_we = 0;
        load_words(6, 1'b0);
        chk("ovf_nwe", 64'(n_we), 64'd4);
        chk("ovf_flag", 64'(load_ovf), 64'd1);
        chk("ovf_state", 64'(state), 64'd2);
        chk("ovf_ready", 64'(load_ready), 64'd0);

        // Reset in the middle of a run.
        run_req = 1; cycle(); run_req = 0;
        repeat (10) cycle();
        chk("mid_count", 64'(cycle_count), 64'd10);
        rst = 1; cycle(); rst = 0;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(cycle_count), 64'd0);
        chk("rst_en", 64'(core_en), 64'd0);
        chk("rst_rstn", 64'(core_rst_n), 64'd0);

        // Counter saturation on the narrow instance.
        wait_state(1, 10);
        load_words(1, 1'b1);
        run_req = 1; cycle(); run_req = 0;
        repeat (20) cycle();
        chk("sat_small", 64'(s_cycle_count), 64'd15);
        chk("sat_wide", 64'(cycle_count), 64'd20);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            load_valid  = $urandom_range(0, 1);
            load_last   = ($urandom_range(0, 3) == 0);
            load_data   = $urandom;
            run_req     = ($urandom_range(0, 7) == 0);
            step_req    = ($urandom_range(0, 7) == 0);
            halt_req    = ($urandom_range(0, 39) == 0);
            restart_req = ($urandom_range(0, 15) == 0);
            ecall_hit   = ($urandom_range(0, 39) == 0);
            cycle();
        end
        idle();
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
